// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned LAT_W  = 4;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Any set bit above the word-index field means the address is outside the array.
  function automatic logic addr_oob(input logic [31:0] addr, input int unsigned aw);
    logic oob;
    oob = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i >= aw) oob = oob | addr[i];
    end
    return oob;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM (read-first); contents are never reset.
module dmem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder with programmable wait-state latency.
// Optional completed-access counters are enabled by defining DMEM_STATS_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [15:0]       stat_reads,
  output logic [15:0]       stat_writes
);

  state_t            r_state, w_next;
  logic [LAT_W-1:0]  r_cnt;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd_ok;
  logic              r_err;

  logic              w_accept, w_commit, w_handshake;
  logic              w_req_ready, w_resp_valid;
  logic              w_cur_write, w_cur_err, w_we;
  logic [31:0]       w_cur_addr;
  logic [DATA_W-1:0] w_cur_wdata, w_ram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next   = RESP;
            w_commit = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == LAT_W'(1)) begin
          w_next   = RESP;
          w_commit = 1'b1;
        end
      end
      RESP: begin
        w_resp_valid = 1'b1;
        if (resp_ready) begin
          w_handshake = 1'b1;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is the accept edge, so the RAM must see the live request.
  assign w_cur_write = (r_state == IDLE) ? req_write : r_write;
  assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_cur_err   = addr_oob(w_cur_addr, ADDR_W);
  assign w_we        = w_commit & w_cur_write & ~w_cur_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd_ok <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= LAT_W'(LATENCY - 1);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - LAT_W'(1);
      end
      if (w_commit) begin
        r_rd_ok <= ~w_cur_write & ~w_cur_err;
        r_err   <= w_cur_err;
      end else if (w_handshake) begin
        r_rd_ok <= 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_cur_addr[ADDR_W-1:0]),
    .wdata (w_cur_wdata),
    .rdata (w_ram_rdata)
  );

  // RAM output is stable through RESP (no writes, fixed address); r_rd_ok masks stores/errors.
  assign req_ready  = w_req_ready;
  assign resp_valid = w_resp_valid;
  assign resp_err   = r_err;
  assign resp_rdata = r_rd_ok ? w_ram_rdata : '0;

`ifdef DMEM_STATS_EN
  logic [STAT_W-1:0] r_stat_rd, r_stat_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_rd <= '0;
      r_stat_wr <= '0;
    end else if (w_handshake && !r_err) begin
      if (r_write) begin
        if (r_stat_wr != '1) r_stat_wr <= r_stat_wr + STAT_W'(1);
      end else begin
        if (r_stat_rd != '1) r_stat_rd <= r_stat_rd + STAT_W'(1);
      end
    end
  end

  assign stat_reads  = r_stat_rd;
  assign stat_writes = r_stat_wr;
`else
  assign stat_reads  = '0;
  assign stat_writes = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 instance for the main flow, LATENCY=1 instance for back-to-back.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  int          checks;
  int          failures;

  logic        a_req_valid, a_req_ready, a_req_write;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic [15:0] a_stat_reads, a_stat_writes;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic [15:0] b_stat_reads, b_stat_writes;

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .stat_reads(a_stat_reads), .stat_writes(a_stat_writes)
  );

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .stat_reads(b_stat_reads), .stat_writes(b_stat_writes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full LATENCY=2 transaction on instance A with resp_ready taken immediately.
  task automatic a_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd;
    check({tag, ".req_ready"}, {31'd0, a_req_ready}, 32'd1);
    tick();
    a_req_valid = 1'b0;
    check({tag, ".wait_valid"}, {31'd0, a_resp_valid}, 32'd0);
    check({tag, ".wait_ready"}, {31'd0, a_req_ready}, 32'd0);
    tick();
    check({tag, ".resp_valid"}, {31'd0, a_resp_valid}, 32'd1);
    check({tag, ".rdata"}, a_resp_rdata, exp_rd);
    check({tag, ".err"}, {31'd0, a_resp_err}, {31'd0, exp_err});
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    check({tag, ".drop_valid"}, {31'd0, a_resp_valid}, 32'd0);
    check({tag, ".drop_rdata"}, a_resp_rdata, 32'd0);
    check({tag, ".drop_err"}, {31'd0, a_resp_err}, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst.req_ready", {31'd0, a_req_ready}, 32'd1);
    check("rst.resp_valid", {31'd0, a_resp_valid}, 32'd0);
    check("rst.rdata", a_resp_rdata, 32'd0);
    check("rst.err", {31'd0, a_resp_err}, 32'd0);
    check("rst.stat_reads", {16'd0, a_stat_reads}, 32'd0);
    check("rst.stat_writes", {16'd0, a_stat_writes}, 32'd0);
    rst = 1'b1;
    tick();

    a_txn(1'b1, 32'h5, 32'hDEADBEEF, 32'h0, 1'b0, "st5");
    a_txn(1'b0, 32'h5, 32'h0, 32'hDEADBEEF, 1'b0, "ld5");
    a_txn(1'b1, 32'h0, 32'h11112222, 32'h0, 1'b0, "st0");

    // Backpressure: load held for 5 cycles with resp_ready low.
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h5;
    tick();
    a_req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", {31'd0, a_resp_valid}, 32'd1);
      check("bp.rdata", a_resp_rdata, 32'hDEADBEEF);
      check("bp.req_ready", {31'd0, a_req_ready}, 32'd0);
      tick();
    end
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    check("bp.drop_valid", {31'd0, a_resp_valid}, 32'd0);
    check("bp.drop_rdata", a_resp_rdata, 32'd0);
    check("bp.idle_ready", {31'd0, a_req_ready}, 32'd1);

    a_txn(1'b0, 32'h400, 32'h0, 32'h0, 1'b1, "ld400");
    a_txn(1'b1, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1, "st400");
    a_txn(1'b0, 32'h0, 32'h0, 32'h11112222, 1'b0, "ld0");

    // LATENCY=1 back-to-back stores with resp_ready tied high.
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h1; b_req_wdata = 32'hA1A1A1A1;
    check("b.acc0_ready", {31'd0, b_req_ready}, 32'd1);
    tick();
    b_req_addr = 32'h2; b_req_wdata = 32'hB2B2B2B2;
    check("b.resp1_valid", {31'd0, b_resp_valid}, 32'd1);
    check("b.resp1_ready", {31'd0, b_req_ready}, 32'd0);
    check("b.resp1_rdata", b_resp_rdata, 32'd0);
    tick();
    check("b.idle_valid", {31'd0, b_resp_valid}, 32'd0);
    check("b.idle_ready", {31'd0, b_req_ready}, 32'd1);
    tick();
    b_req_valid = 1'b0;
    check("b.resp2_valid", {31'd0, b_resp_valid}, 32'd1);
    check("b.resp2_err", {31'd0, b_resp_err}, 32'd0);
    tick();
    check("b.end_valid", {31'd0, b_resp_valid}, 32'd0);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h1;
    tick();
    b_req_valid = 1'b0;
    check("b.ld1_rdata", b_resp_rdata, 32'hA1A1A1A1);
    tick();
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h2;
    tick();
    b_req_valid = 1'b0;
    check("b.ld2_rdata", b_resp_rdata, 32'hB2B2B2B2);
    tick();

    // Reset during WAIT of a store to 0x7 must discard it.
    a_txn(1'b1, 32'h7, 32'h00000055, 32'h0, 1'b0, "st7a");
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h7; a_req_wdata = 32'h1234;
    tick();
    a_req_valid = 1'b0;
    check("rw.in_wait", {31'd0, a_req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rw.req_ready", {31'd0, a_req_ready}, 32'd1);
    check("rw.resp_valid", {31'd0, a_resp_valid}, 32'd0);
    check("rw.rdata", a_resp_rdata, 32'd0);
    @(negedge clk);
    tick();
    rst = 1'b1;
    tick();
    a_txn(1'b0, 32'h7, 32'h0, 32'h00000055, 1'b0, "ld7");

    // Statistics since reset: loads 7,5,0; stores 9,A; one error load.
    a_txn(1'b0, 32'h5, 32'h0, 32'hDEADBEEF, 1'b0, "sld5");
    a_txn(1'b1, 32'h9, 32'h99, 32'h0, 1'b0, "sst9");
    a_txn(1'b0, 32'h800, 32'h0, 32'h0, 1'b1, "sld800");
    a_txn(1'b1, 32'hA, 32'hAA, 32'h0, 1'b0, "sstA");
    a_txn(1'b0, 32'h0, 32'h0, 32'h11112222, 1'b0, "sld0");
`ifdef DMEM_STATS_EN
    check("stat_reads", {16'd0, a_stat_reads}, 32'd3);
    check("stat_writes", {16'd0, a_stat_writes}, 32'd2);
`else
    check("stat_reads", {16'd0, a_stat_reads}, 32'd0);
    check("stat_writes", {16'd0, a_stat_writes}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory responder: the target end of the datapath's load/store interface.
- Accepts one word read/write request at a time and services it after a programmable wait-state latency.
- Returns read data and an error flag over a response handshake with backpressure.
- Sits between the MiniRISC datapath (or a multi-cycle bus master) and word storage; replaces a zero-wait-state RAM when memory timing is non-ideal.

Parameters:
- ADDR_W, 10, word-index width; memory depth = 2**ADDR_W words.
- DATA_W, 32, word width.
- LATENCY, 2, cycles from request accept to first resp_valid cycle; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  word address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator takes the response.
- resp_rdata  out  DATA_W  load data; 0 for stores and errors.
- resp_err  out  1  address out of range.
- stat_reads  out  16  completed-load count (see Optional Feature).
- stat_writes  out  16  completed-store count.

Behaviour:
- Reset (rst low, async):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; stats = 0.
  - Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Accept on req_valid & req_ready at the same rising edge.
  - Latch req_write, req_addr, req_wdata.
  - Load wait counter with LATENCY-1.
  - If LATENCY == 1, go directly to RESP; otherwise go to WAIT.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; at 1 -> RESP.
  - Request inputs are ignored.
- Entering RESP (single edge):
  - Error check: err = |req_addr[31:ADDR_W].
  - Store with !err: mem[req_addr[ADDR_W-1:0]] <= wdata.
  - Load with !err: resp_rdata <= mem[index].
  - err: no memory write, resp_rdata = 0, resp_err = 1.
- Latency: resp_valid is first high exactly LATENCY cycles after the accepting edge.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid & resp_ready.
  - On that edge: -> IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - The next request can be accepted no earlier than the following edge.
  - Minimum request-to-request spacing = LATENCY + 1 cycles.
- A request held on req_valid while not in IDLE is not lost. It is accepted on the first IDLE cycle; the initiator must hold it stable.
- Read-after-write to the same index returns the newly written data, because the store commits before the next accept.
- Reset mid-operation: a pending store is discarded if its commit edge has not yet occurred; the response is dropped.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - stat_reads and stat_writes increment on each completed (handshaked) non-error load/store.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: both ports are tied to 16'h0000 and no counter flops are generated.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - LAT_W = 4;
  - STAT_W = 16.
- Sub-module dmem_array:
  - synchronous single-port word RAM;
  - ports: clk, we, addr, wdata, rdata;
  - no reset;
  - instantiated once.
- All handshake and FSM logic stays in dmem_responder.

Test Plan:
- LATENCY=2: store addr 0x5, data 0xDEADBEEF, accepted at cycle 0 -> resp_valid at cycle 2, resp_err=0, resp_rdata=0. Then a load of 0x5 -> resp_rdata=0xDEADBEEF two cycles after its accept.
- resp_ready held low for 5 cycles during a load response -> resp_valid/resp_rdata stable throughout, req_ready=0; drop on the edge resp_ready rises.
- Load addr 0x0000_0400 with ADDR_W=10 -> resp_err=1, resp_rdata=0. Store to 0x400 leaves mem[0] unchanged (verified by a later load of 0x0).
- LATENCY=1: back-to-back stores to 0x1 and 0x2 with resp_ready tied high -> accepts at cycles 0 and 2, responses at cycles 1 and 3.
- Assert rst low during WAIT of a store to 0x7 (data 0x1234) -> outputs at reset values immediately; a subsequent load of 0x7 returns the prior contents.
- DMEM_STATS_EN defined: 3 loads, 2 stores, 1 error load -> stat_reads=3, stat_writes=2. Undefined: both remain 0.
